ifu_fetch_sequencer: RTL
========================

Name: ifu_fetch_sequencer

Overview:
Sequences instruction fetch for the IFU. Holds the 4-bit program counter and issues request/acknowledge reads to instruction memory. Advances the PC through an instance of the 4-bit incrementer. Hands each fetched instruction to decode over a valid/ready handshake, and supports start, halt and branch redirect.

Parameters:
IW, 16, instruction word width in bits
BOOT_PC, 4'h0, PC value loaded at reset

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  reset; asynchronous, active-low
start  in  1  begin fetching from current PC (honoured only in IDLE)
halt  in  1  stop after the in-flight instruction is delivered
redirect_valid  in  1  branch redirect strobe
redirect_pc  in  4  redirect target address
imem_req  out  1  instruction memory read request
imem_addr  out  4  instruction memory address
imem_ack  in  1  memory has read data; imem_rdata valid this cycle
imem_rdata  in  IW  instruction word from memory
inst_valid  out  1  instruction available to decode
inst_data  out  IW  fetched instruction
inst_pc  out  4  address of inst_data
inst_ready  in  1  decode accepts instruction
busy  out  1  high in any state other than IDLE
wrap  out  1  one-cycle pulse: PC incremented from 4'hF to 4'h0

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc=BOOT_PC, state=IDLE, halt_pending=0.
  - imem_req=0, inst_valid=0, inst_data=0, inst_pc=0, busy=0, wrap=0.
- imem_addr = pc at all times (combinational).
- FSM states: IDLE, FETCH, DELIVER. All outputs except imem_addr are registered or decoded from state.
- IDLE:
  - start=1 and halt=0 -> FETCH; imem_req=1 from the next cycle.
  - start=1 with halt=1 in the same cycle -> stay IDLE.
- FETCH:
  - imem_req=1 and imem_addr is held until imem_ack.
  - On imem_ack in cycle N:
    - inst_data<=imem_rdata and inst_pc<=pc.
    - inst_valid=1 from cycle N+1.
    - pc<=pc+1 (incrementer output, modulo 16).
    - state -> DELIVER.
  - Fetch latency: ack cycle to inst_valid is exactly 1 cycle.
- DELIVER:
  - imem_req=0; inst_valid, inst_data and inst_pc stay stable until inst_ready=1.
  - On inst_ready in cycle M, inst_valid=0 in cycle M+1, then:
    - halt_pending=1 or halt=1 -> IDLE, and halt_pending clears.
    - otherwise -> FETCH.
  - Minimum spacing: 2 cycles per instruction.
- Halt:
  - halt in FETCH or DELIVER sets halt_pending.
  - The current fetch completes and is delivered before entering IDLE; it is never dropped.
  - halt in IDLE has no effect.
- Redirect (highest priority, any state):
  - pc<=redirect_pc and inst_valid<=0 next cycle.
  - Any imem_ack in the same cycle is discarded.
  - In FETCH or DELIVER -> FETCH, and imem_addr shows the new target the next cycle.
  - In IDLE -> pc updated, state stays IDLE.
  - Redirect does not clear halt_pending; a pending halt is taken after the redirected instruction is delivered.
  - Memory contract: the address may change while imem_req is high and no ack has been given.
- wrap pulses exactly one cycle after the increment from 4'hF. A redirect to 4'h0 does not pulse wrap.
- start outside IDLE is ignored.
- Mid-operation reset clears everything immediately. The memory must tolerate imem_req dropping before ack.

Decomposition:
- Shared package ifu_pkg:
  - typedef pc_t = logic[3:0].
  - enum fetch_state_e {IDLE, FETCH, DELIVER}.
  - constant PC_MAX = 4'hF.
- One sub-module: inc4bit, instantiated for pc+1. No other arithmetic in the block.

Test Plan:
- Reset, start pulse, memory acks 1 cycle after each req with rdata=16'hA000+addr, inst_ready tied 1:
  - addresses 0,1,2,... are fetched.
  - inst_data/inst_pc pairs are (A000,0), (A001,1), (A002,2).
  - inst_valid is 1 cycle after each ack.
- Backpressure: hold inst_ready=0 for 5 cycles after inst_valid at pc=3:
  - inst_data and inst_pc stay stable throughout; imem_req=0.
  - After ready, the next request address is 4.
- Wrap: redirect to 4'hE, then fetch 3 instructions:
  - inst_pc sequence is E, F, 0.
  - wrap pulses for exactly one cycle after the F fetch ack.
- Redirect with simultaneous imem_ack in FETCH at pc=5, redirect_pc=9:
  - data for address 5 is discarded and inst_valid stays 0.
  - The next imem_addr is 9; the delivered inst_pc is 9.
- Halt asserted in FETCH at pc=2:
  - the pc=2 instruction is still delivered.
  - The block then enters IDLE with busy=0 and pc=3.
  - start while busy is ignored; start in IDLE resumes at 3.
- Assert rst_n=0 asynchronously mid-FETCH:
  - imem_req, inst_valid and busy drop without a clock edge.
  - pc=BOOT_PC after release.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types for the instruction fetch unit: PC type, fetch FSM states, PC limit.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package ifu_pkg;

    typedef logic [3:0] pc_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DELIVER = 2'd2
    } fetch_state_e;

    localparam pc_t PC_MAX = 4'hF;

endpackage

// File: rtl/ifu_fetch_sequencer_inc4bit.sv
// 4-bit incrementer with carry out; carry marks the PC_MAX -> 0 rollover.
// Latency: combinational.
// Backpressure: not applicable.
module inc4bit
    import ifu_pkg::*;
(
    input  pc_t  a,
    output pc_t  sum,
    output logic carry
);

    assign {carry, sum} = {1'b0, a} + 5'd1;

endmodule

// File: rtl/ifu_fetch_sequencer.sv
// Fetch sequencer: holds the PC, reads imem with req/ack, hands words to decode.
// Latency: ack to inst_valid is 1 cycle; at most one instruction every 2 cycles.
// Backpressure: inst_ready low holds the instruction stable and stalls further fetches.
module ifu_fetch_sequencer
    import ifu_pkg::*;
#(
    parameter int  IW      = 16,
    parameter pc_t BOOT_PC = 4'h0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          halt,
    input  logic          redirect_valid,
    input  logic [3:0]    redirect_pc,
    output logic          imem_req,
    output logic [3:0]    imem_addr,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_rdata,
    output logic          inst_valid,
    output logic [IW-1:0] inst_data,
    output logic [3:0]    inst_pc,
    input  logic          inst_ready,
    output logic          busy,
    output logic          wrap
);

    fetch_state_e  state_q, state_d;
    pc_t           pc_q, pc_d;
    pc_t           inst_pc_q, inst_pc_d;
    pc_t           pc_inc;
    logic          pc_carry;
    logic          halt_pending_q, halt_pending_d;
    logic          wrap_q, wrap_d;
    logic [IW-1:0] inst_data_q, inst_data_d;

    inc4bit u_inc (
        .a     (pc_q),
        .sum   (pc_inc),
        .carry (pc_carry)
    );

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        inst_pc_d      = inst_pc_q;
        inst_data_d    = inst_data_q;
        wrap_d         = 1'b0;
        halt_pending_d = halt_pending_q | (halt & (state_q != IDLE));

        // Redirect wins over everything, including an ack landing in the same cycle.
        if (redirect_valid) begin
            pc_d = redirect_pc;
            if (state_q != IDLE) begin
                state_d = FETCH;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !halt) begin
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        inst_data_d = imem_rdata;
                        inst_pc_d   = pc_q;
                        pc_d        = pc_inc;
                        wrap_d      = pc_carry;
                        state_d     = DELIVER;
                    end
                end
                DELIVER: begin
                    if (inst_ready) begin
                        if (halt_pending_q || halt) begin
                            state_d        = IDLE;
                            halt_pending_d = 1'b0;
                        end else begin
                            state_d = FETCH;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            pc_q           <= BOOT_PC;
            inst_pc_q      <= '0;
            inst_data_q    <= '0;
            halt_pending_q <= 1'b0;
            wrap_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            inst_pc_q      <= inst_pc_d;
            inst_data_q    <= inst_data_d;
            halt_pending_q <= halt_pending_d;
            wrap_q         <= wrap_d;
        end
    end

    assign imem_addr  = pc_q;
    assign imem_req   = (state_q == FETCH);
    assign inst_valid = (state_q == DELIVER);
    assign busy       = (state_q != IDLE);
    assign wrap       = wrap_q;
    assign inst_data  = inst_data_q;
    assign inst_pc    = inst_pc_q;

endmodule
